// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// Follows branch-unit redirects and hands fetched words to decode over valid/ready.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        pc_offset_en,
    input  logic [31:0] pc_offset,
    input  logic        pc_override,
    output logic        misalign
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        drop;
    logic        drop_next;
    logic        capture;
    logic        misalign_next;

    logic        taken;
    logic [31:0] target;
    logic        accept;
    logic        handshake;

    logic [31:0] data_p1;
    logic [31:0] pc_p1;
    logic [31:0] link_p1;
    logic        misalign_p1;

    // Absolute targets drop bit 0; relative targets wrap modulo 2^32.
    function automatic logic [31:0] redirect_target(
        input logic [31:0] base,
        input logic [31:0] offset,
        input logic        absolute
    );
        logic signed [31:0] base_s;
        logic signed [31:0] offset_s;
        logic signed [31:0] sum_s;
        base_s   = $signed(base);
        offset_s = $signed(offset);
        sum_s    = base_s + offset_s;
        if (absolute) begin
            return offset & 32'hFFFF_FFFE;
        end
        return $unsigned(sum_s);
    endfunction

    function automatic logic [31:0] link_address(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    assign taken     = redir_valid & (pc_offset_en | pc_override);
    assign target    = redirect_target(redir_pc, pc_offset, pc_override);
    assign accept    = (state == REQ) & imem_req_ready;
    assign handshake = (state == HOLD) & inst_ready;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        drop_next     = drop;
        capture       = 1'b0;
        misalign_next = 1'b0;

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_next = 1'b0;
                    if (drop || taken) begin
                        state_next = REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    pc_next    = link_address(pc);
                    state_next = REQ;
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase

        // A redirect overrides the sequential decisions above; HALT ignores it.
        if (taken && (state != HALT)) begin
            if (target[1]) begin
                state_next    = HALT;
                pc_next       = pc;
                drop_next     = 1'b0;
                capture       = 1'b0;
                misalign_next = 1'b1;
            end else begin
                pc_next = target;
                case (state)
                    REQ: begin
                        if (accept) begin
                            drop_next = 1'b1;
                        end
                    end
                    WAIT: begin
                        if (!imem_rsp_valid) begin
                            drop_next = 1'b1;
                        end
                    end
                    HOLD: state_next = REQ;
                    default: ;
                endcase
            end
        end
    end

    // Stage p0 -> p1: control state and captured instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            misalign_p1 <= 1'b0;
            data_p1     <= 32'h0;
            pc_p1       <= 32'h0;
            link_p1     <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            drop        <= drop_next;
            misalign_p1 <= misalign_next;
            if (capture) begin
                data_p1 <= imem_rsp_data;
                pc_p1   <= pc;
                link_p1 <= link_address(pc);
            end
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);
    assign inst_data      = data_p1;
    assign inst_pc        = pc_p1;
    assign inst_pc_plus4  = link_p1;
    assign misalign       = misalign_p1;

endmodule
